// File: rtl/main_fsm_if.sv
// Memory-side handshake bundle between main_fsm and the cache.
// The FSM uses the master modport and the cache uses the slave modport.
interface main_fsm_if;
    logic i_mem_done;
    logic o_mem_req;
    logic o_mem_write;
    logic o_addr_src;

    modport master (
        input  i_mem_done,
        output o_mem_req,
        output o_mem_write,
        output o_addr_src
    );

    modport slave (
        output i_mem_done,
        input  o_mem_req,
        input  o_mem_write,
        input  o_addr_src
    );
endinterface

// File: rtl/main_fsm.sv
// Multicycle RV64I control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Optional macro ILLEGAL_INSTR_TRAP_EN: unknown opcodes enter a sticky FAULT state that raises o_fault.
module main_fsm #(
    parameter int OP_WIDTH  = 7,
    parameter int SEL_WIDTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [OP_WIDTH-1:0]  i_op,
    main_fsm_if.master           mem,
    output logic                 o_ir_write,
    output logic                 o_pc_update,
    output logic                 o_branch,
    output logic                 o_reg_write,
    output logic [SEL_WIDTH-1:0] o_alu_src_a,
    output logic [SEL_WIDTH-1:0] o_alu_src_b,
    output logic [SEL_WIDTH-1:0] o_alu_op,
    output logic [SEL_WIDTH-1:0] o_result_src,
    output logic                 o_fault
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_RW     = 7'b0111011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_IW     = 7'b0011011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [SEL_WIDTH-1:0] SA_PC    = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] SA_OLDPC = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] SA_RD1   = SEL_WIDTH'(2);
    localparam logic [SEL_WIDTH-1:0] SB_RD2   = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] SB_IMM   = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] SB_FOUR  = SEL_WIDTH'(2);
    localparam logic [SEL_WIDTH-1:0] AO_ADD   = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] AO_SUB   = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] AO_FUNCT = SEL_WIDTH'(2);
    localparam logic [SEL_WIDTH-1:0] AO_PASSB = SEL_WIDTH'(3);
    localparam logic [SEL_WIDTH-1:0] RS_ALUOUT = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] RS_RDATA  = SEL_WIDTH'(1);

`ifdef ILLEGAL_INSTR_TRAP_EN
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, JAL, JALR, JALR_PC, BRANCH, LUI, AUIPC, FAULT
    } state_t;
`else
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, JAL, JALR, JALR_PC, BRANCH, LUI, AUIPC
    } state_t;
`endif

    state_t state_q, state_d;

    logic [6:0] op;
    logic       mem_req, mem_write, addr_src, fault;

    assign op              = i_op[6:0];
    assign mem.o_mem_req   = mem_req;
    assign mem.o_mem_write = mem_write;
    assign mem.o_addr_src  = addr_src;

    always_ff @(posedge i_clk) begin
        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        addr_src     = 1'b0;
        fault        = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_update  = 1'b0;
        o_branch     = 1'b0;
        o_reg_write  = 1'b0;
        o_alu_src_a  = SA_PC;
        o_alu_src_b  = SB_RD2;
        o_alu_op     = AO_ADD;
        o_result_src = RS_ALUOUT;

        case (state_q)
            FETCH: begin
                mem_req     = 1'b1;
                o_alu_src_b = SB_FOUR;
                if (mem.i_mem_done) begin
                    o_ir_write  = 1'b1;
                    o_pc_update = 1'b1;
                    state_d     = DECODE;
                end
            end
            DECODE: begin
                o_alu_src_a = SA_OLDPC;
                o_alu_src_b = SB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R, OP_RW:       state_d = EXECR;
                    OP_I, OP_IW:       state_d = EXECI;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = AUIPC;
`ifdef ILLEGAL_INSTR_TRAP_EN
                    default:           state_d = FAULT;
`else
                    default:           state_d = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                o_alu_src_a = SA_RD1;
                o_alu_src_b = SB_IMM;
                state_d     = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                if (mem.i_mem_done) state_d = MEMWB;
            end
            MEMWB: begin
                o_result_src = RS_RDATA;
                o_reg_write  = 1'b1;
                state_d      = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                addr_src  = 1'b1;
                if (mem.i_mem_done) state_d = FETCH;
            end
            EXECR: begin
                o_alu_src_a = SA_RD1;
                o_alu_src_b = SB_RD2;
                o_alu_op    = AO_FUNCT;
                state_d     = ALUWB;
            end
            EXECI: begin
                o_alu_src_a = SA_RD1;
                o_alu_src_b = SB_IMM;
                o_alu_op    = AO_FUNCT;
                state_d     = ALUWB;
            end
            ALUWB: begin
                o_reg_write = 1'b1;
                state_d     = FETCH;
            end
            // PC takes the target already in ALUOut while the ALU forms the link value OldPC+4.
            JAL, JALR_PC: begin
                o_alu_src_a = SA_OLDPC;
                o_alu_src_b = SB_FOUR;
                o_pc_update = 1'b1;
                state_d     = ALUWB;
            end
            JALR: begin
                o_alu_src_a = SA_RD1;
                o_alu_src_b = SB_IMM;
                state_d     = JALR_PC;
            end
            BRANCH: begin
                o_alu_src_a = SA_RD1;
                o_alu_src_b = SB_RD2;
                o_alu_op    = AO_SUB;
                o_branch    = 1'b1;
                state_d     = FETCH;
            end
            LUI: begin
                o_alu_src_b = SB_IMM;
                o_alu_op    = AO_PASSB;
                state_d     = ALUWB;
            end
            AUIPC: begin
                o_alu_src_a = SA_OLDPC;
                o_alu_src_b = SB_IMM;
                state_d     = ALUWB;
            end
`ifdef ILLEGAL_INSTR_TRAP_EN
            FAULT: begin
                fault = 1'b1;
            end
`endif
            default: state_d = FETCH;
        endcase

        if (i_rst) begin
            state_d      = FETCH;
            mem_req      = 1'b0;
            mem_write    = 1'b0;
            addr_src     = 1'b0;
            fault        = 1'b0;
            o_ir_write   = 1'b0;
            o_pc_update  = 1'b0;
            o_branch     = 1'b0;
            o_reg_write  = 1'b0;
            o_alu_src_a  = '0;
            o_alu_src_b  = '0;
            o_alu_op     = '0;
            o_result_src = '0;
        end
    end

`ifdef ILLEGAL_INSTR_TRAP_EN
    assign o_fault = fault;
`else
    assign o_fault = 1'b0;
    logic unused_fault;
    assign unused_fault = fault;
`endif

endmodule
